// File: rtl/cache_mem_arbiter_if.sv
// ============================================================================
// cache_mem_arbiter_if : cache-side and memory-side signals of the arbiter
// Revision: 1.0
// ============================================================================
`default_nettype none

interface cache_mem_arbiter_if;
  logic        i_req;
  logic [63:0] i_addr;
  logic [63:0] i_rdata;
  logic        i_done;
  logic        i_busy;

  logic        d_rreq;
  logic        d_wreq;
  logic [63:0] d_addr;
  logic [63:0] d_wdata;
  logic [7:0]  d_wstrb;
  logic [63:0] d_rdata;
  logic        d_done;
  logic        d_busy;

  logic        m_valid;
  logic        m_we;
  logic [63:0] m_addr;
  logic [63:0] m_wdata;
  logic [7:0]  m_wstrb;
  logic        m_ready;
  logic        m_done;
  logic [63:0] m_rdata;

  modport slave (
    input  i_req, i_addr, d_rreq, d_wreq, d_addr, d_wdata, d_wstrb,
           m_ready, m_done, m_rdata,
    output i_rdata, i_done, i_busy, d_rdata, d_done, d_busy,
           m_valid, m_we, m_addr, m_wdata, m_wstrb
  );

  modport master (
    output i_req, i_addr, d_rreq, d_wreq, d_addr, d_wdata, d_wstrb,
           m_ready, m_done, m_rdata,
    input  i_rdata, i_done, i_busy, d_rdata, d_done, d_busy,
           m_valid, m_we, m_addr, m_wdata, m_wstrb
  );
endinterface

`default_nettype wire

// File: rtl/cache_mem_arbiter.sv
// ============================================================================
// cache_mem_arbiter : shares one memory request port between I- and D-cache
// Revision: 1.0
// ============================================================================
`default_nettype none

module cache_mem_arbiter #(
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  wire logic          clk,
  input  wire logic          rst,
  cache_mem_arbiter_if.slave bus
);

  localparam logic [3:0] c_LIMIT = 4'(STARVE_LIMIT);

  typedef enum logic [3:0] {
    IDLE  = 4'b0001,
    ISSUE = 4'b0010,
    WAIT  = 4'b0100,
    RESP  = 4'b1000
  } state_e;

  state_e      state_q, state_d;
  logic        own_i_q, own_i_d;
  logic        own_d_q, own_d_d;
  logic        we_q, we_d;
  logic [63:0] addr_q, addr_d;
  logic [63:0] wdata_q, wdata_d;
  logic [7:0]  wstrb_q, wstrb_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [63:0] i_rdata_q, i_rdata_d;
  logic [63:0] d_rdata_q, d_rdata_d;
  logic        m_valid_q;
  logic        i_done_q;
  logic        d_done_q;

  logic        w_d_any;
  logic        w_grant_i;
  logic        w_capture;

  assign w_d_any   = bus.d_wreq | bus.d_rreq;
  // The I-cache wins when D is silent or once D has starved it long enough.
  assign w_grant_i = bus.i_req & ((cnt_q >= c_LIMIT) | ~w_d_any);

  always_comb begin
    state_d   = state_q;
    own_i_d   = own_i_q;
    own_d_d   = own_d_q;
    we_d      = we_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    wstrb_d   = wstrb_q;
    cnt_d     = cnt_q;
    w_capture = 1'b0;

    case (state_q)
      IDLE: begin
        if (w_grant_i) begin
          own_i_d = 1'b1;
          we_d    = 1'b0;
          addr_d  = bus.i_addr;
          wstrb_d = 8'h00;
          cnt_d   = 4'd0;
          state_d = ISSUE;
        end else if (w_d_any) begin
          own_d_d = 1'b1;
          we_d    = bus.d_wreq;
          addr_d  = bus.d_addr;
          if (bus.d_wreq) begin
            wdata_d = bus.d_wdata;
            wstrb_d = bus.d_wstrb;
          end else begin
            wstrb_d = 8'h00;
          end
          if (bus.i_req) begin
            cnt_d = (cnt_q == 4'hF) ? cnt_q : cnt_q + 4'd1;
          end else begin
            cnt_d = 4'd0;
          end
          state_d = ISSUE;
        end
      end
      ISSUE: begin
        if (bus.m_ready) begin
          if (bus.m_done) begin
            w_capture = 1'b1;
            state_d   = RESP;
          end else begin
            state_d   = WAIT;
          end
        end
      end
      WAIT: begin
        if (bus.m_done) begin
          w_capture = 1'b1;
          state_d   = RESP;
        end
      end
      RESP: begin
        own_i_d = 1'b0;
        own_d_d = 1'b0;
        state_d = IDLE;
      end
      default: begin
        own_i_d = 1'b0;
        own_d_d = 1'b0;
        state_d = IDLE;
      end
    endcase
  end

  // Write responses leave the D-cache read data untouched.
  always_comb begin
    i_rdata_d = i_rdata_q;
    d_rdata_d = d_rdata_q;
    if (w_capture) begin
      if (own_i_q) begin
        i_rdata_d = bus.m_rdata;
      end else if (!we_q) begin
        d_rdata_d = bus.m_rdata;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= IDLE;
      own_i_q   <= 1'b0;
      own_d_q   <= 1'b0;
      we_q      <= 1'b0;
      addr_q    <= 64'd0;
      wdata_q   <= 64'd0;
      wstrb_q   <= 8'h00;
      cnt_q     <= 4'd0;
      i_rdata_q <= 64'd0;
      d_rdata_q <= 64'd0;
      m_valid_q <= 1'b0;
      i_done_q  <= 1'b0;
      d_done_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      own_i_q   <= own_i_d;
      own_d_q   <= own_d_d;
      we_q      <= we_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      wstrb_q   <= wstrb_d;
      cnt_q     <= cnt_d;
      i_rdata_q <= i_rdata_d;
      d_rdata_q <= d_rdata_d;
      m_valid_q <= (state_d == ISSUE);
      i_done_q  <= (state_d == RESP) & own_i_d;
      d_done_q  <= (state_d == RESP) & own_d_d;
    end
  end

  assign bus.m_valid = m_valid_q;
  assign bus.m_we    = we_q;
  assign bus.m_addr  = addr_q;
  assign bus.m_wdata = wdata_q;
  assign bus.m_wstrb = wstrb_q;
  assign bus.i_rdata = i_rdata_q;
  assign bus.d_rdata = d_rdata_q;
  assign bus.i_done  = i_done_q;
  assign bus.d_done  = d_done_q;
  assign bus.i_busy  = own_i_q;
  assign bus.d_busy  = own_d_q;

endmodule

`default_nettype wire
